lsu_mem: RTL

- Load/store stage directly downstream of the single-cycle datapath.
- Consumes the datapath's ALUResult (address) and WriteData; returns ReadData to the datapath's result mux.
- Models a slow on-chip data RAM with programmable wait states.
- Raises Stall so the controller freezes the PC and register writes until the access completes.
- Supports word and byte accesses (LDR/STR/LDRB/STRB).

---
 rtl/lsu_mem.sv | 87 ++++++++
 1 files changed

// File: rtl/lsu_mem.sv
// lsu_mem: load/store stage with a wait-stated data RAM, word/byte access and stall handshake.
// Define LSU_FAULT_EN to enable alignment/range faulting; otherwise addresses align down and wrap.
module lsu_mem #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        ByteEn,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        Done,
    output logic        Fault
);
    localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
    localparam bit BYPASS = WAIT_STATES == 0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] addr_q, wdata_q;
    logic        byte_q, write_q;
    logic [31:0] mem [DEPTH_WORDS];

    logic        req, bad, accept, access, wait_last;
    logic [31:0] a_addr, a_wdata, rword;
    logic        a_byte, a_write;
    logic [AW-1:0] idx;
    logic [4:0]  sh;

`ifdef LSU_FAULT_EN
    assign bad = (!ByteEn && ALUResult[1:0] != 2'b00) || ALUResult[31:2] >= 30'(DEPTH_WORDS);
`else
    assign bad = 1'b0;
`endif

    assign req       = MemRead | MemWrite;
    assign accept    = state == IDLE && req && !bad;
    assign Fault     = state == IDLE && req && bad;
    assign Stall     = accept || state == WAIT;
    assign wait_last = cnt == 4'(WAIT_STATES - 1);
    assign access    = BYPASS ? accept : (state == WAIT && wait_last);

    // With no wait states the RAM is accessed straight from the live request.
    assign a_addr  = BYPASS ? ALUResult : addr_q;
    assign a_wdata = BYPASS ? WriteData : wdata_q;
    assign a_byte  = BYPASS ? ByteEn : byte_q;
    assign a_write = BYPASS ? MemWrite : write_q;
    assign idx     = AW'(a_addr[31:2] % 30'(DEPTH_WORDS));
    assign sh      = {a_addr[1:0], 3'b000};
    assign rword   = mem[idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            ReadData <= 32'd0;
            Done     <= 1'b0;
        end else begin
            Done  <= access;
            state <= state == IDLE ? (accept ? (BYPASS ? RESP : WAIT) : IDLE)
                   : state == WAIT ? (wait_last ? RESP : WAIT) : IDLE;
            cnt   <= (state == WAIT && !wait_last) ? cnt + 4'd1 : 4'd0;
            if (access && !a_write)
                ReadData <= a_byte ? {24'd0, rword[sh +: 8]} : rword;
        end
        if (accept) begin
            addr_q  <= ALUResult;
            wdata_q <= WriteData;
            byte_q  <= ByteEn;
            write_q <= MemWrite;
        end
    end

    // RAM contents survive reset; an access coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (!reset && access && a_write) begin
            if (a_byte) mem[idx][sh +: 8] <= a_wdata[7:0];
            else mem[idx] <= a_wdata;
        end
    end
endmodule
